// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants, the window-feeder state type and a counter-width helper.
package cnn_pkg;

   localparam int unsigned CNN_DW    = 16;
   localparam int unsigned CNN_IMG_W = 28;
   localparam int unsigned CNN_IMG_H = 28;
   localparam int unsigned CNN_POOL  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_READ,
      ST_WAIT,
      ST_DONE
   } feed_state_t;

   // Counter width for a modulo-n counter, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window/pixel counters for the pooling feeder, plus the RAM read address and output window index.
module pool_addr_gen
   import cnn_pkg::*;
#(
   parameter int unsigned IMG_W   = CNN_IMG_W,
   parameter int unsigned IMG_H   = CNN_IMG_H,
   parameter int unsigned POOL    = CNN_POOL,
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned OADDR_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               pix_adv,
   input  logic               win_adv,
   output logic               last_pix,
   output logic               last_win,
   output logic [ADDR_W-1:0]  addr,
   output logic [OADDR_W-1:0] win_idx
);

   localparam int unsigned OW = IMG_W / POOL;
   localparam int unsigned OH = IMG_H / POOL;
   localparam int unsigned PW = cnt_w(POOL);
   localparam int unsigned CW = cnt_w(OW);
   localparam int unsigned RW = cnt_w(OH);

   logic [PW-1:0] dr;
   logic [PW-1:0] dc;
   logic [CW-1:0] wc;
   logic [RW-1:0] wr;
   logic          dc_last;
   logic          dr_last;
   logic          wc_last;
   logic          wr_last;
   logic [ADDR_W-1:0] row;

   assign dc_last  = (dc == PW'(POOL - 1));
   assign dr_last  = (dr == PW'(POOL - 1));
   assign wc_last  = (wc == CW'(OW - 1));
   assign wr_last  = (wr == RW'(OH - 1));
   assign last_pix = dc_last && dr_last;
   assign last_win = wc_last && wr_last;

   // dc wraps into dr inside a window; wc wraps into wr across windows.
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         dr <= '0;
         dc <= '0;
         wr <= '0;
         wc <= '0;
      end else begin
         if (pix_adv) begin
            dc <= dc_last ? '0 : dc + 1'b1;
            if (dc_last) dr <= dr_last ? '0 : dr + 1'b1;
         end
         if (win_adv) begin
            wc <= wc_last ? '0 : wc + 1'b1;
            if (wc_last) wr <= wr_last ? '0 : wr + 1'b1;
         end
      end
   end

   assign row     = ADDR_W'(wr) * ADDR_W'(POOL) + ADDR_W'(dr);
   assign addr    = row * ADDR_W'(IMG_W) + ADDR_W'(wc) * ADDR_W'(POOL) + ADDR_W'(dc);
   assign win_idx = OADDR_W'(wr) * OADDR_W'(OW) + OADDR_W'(wc);

endmodule

// File: rtl/pool_window_feeder.sv
// Streams each POOLxPOOL window of a row-major feature map from RAM into the max-pooling unit
// and flags when the pooling register holds a finished window maximum.
module pool_window_feeder
   import cnn_pkg::*;
#(
   parameter int unsigned IMG_W   = CNN_IMG_W,
   parameter int unsigned IMG_H   = CNN_IMG_H,
   parameter int unsigned POOL    = CNN_POOL,
   parameter int unsigned DW      = CNN_DW,
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned OADDR_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               hold,
   output logic               rd_en,
   output logic [ADDR_W-1:0]  rd_addr,
   input  logic [DW-1:0]      rd_data,
   output logic [DW-1:0]      pix,
   output logic               pix_valid,
   output logic               block_change,
   output logic               win_done,
   output logic [OADDR_W-1:0] win_addr,
   output logic               busy,
   output logic               done
);

   feed_state_t        state;
   feed_state_t        state_nx;
   logic               pix_adv;
   logic               win_adv;
   logic               last_pix;
   logic               last_win;
   logic               clr;
   logic [ADDR_W-1:0]  addr;
   logic [OADDR_W-1:0] win_idx;
   logic               block_change_nx;
   logic               win_done_nx;
   logic [OADDR_W-1:0] win_addr_nx;
   logic               busy_nx;
   logic               done_nx;

   pool_addr_gen #(
      .IMG_W   (IMG_W),
      .IMG_H   (IMG_H),
      .POOL    (POOL),
      .ADDR_W  (ADDR_W),
      .OADDR_W (OADDR_W)
   ) u_addr_gen (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .pix_adv  (pix_adv),
      .win_adv  (win_adv),
      .last_pix (last_pix),
      .last_win (last_win),
      .addr     (addr),
      .win_idx  (win_idx)
   );

   // Reads react to hold in the same cycle, so the read strobe is decoded rather than registered.
   assign clr     = (state == ST_IDLE);
   assign rd_en   = (state == ST_CLEAR) || ((state == ST_READ) && !hold);
   assign rd_addr = rd_en ? addr : '0;
   assign pix     = pix_valid ? rd_data : '0;

   always_comb begin
      state_nx        = state;
      pix_adv         = 1'b0;
      win_adv         = 1'b0;
      win_done_nx     = 1'b0;
      win_addr_nx     = '0;
      block_change_nx = 1'b0;
      busy_nx         = 1'b0;
      done_nx         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nx = ST_CLEAR;
         end
         ST_CLEAR: begin
            pix_adv  = 1'b1;
            state_nx = last_pix ? ST_WAIT : ST_READ;
         end
         ST_READ: begin
            if (!hold) begin
               pix_adv = 1'b1;
               if (last_pix) state_nx = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Last pixel lands in the pooling register now; report this window next cycle.
            win_done_nx = 1'b1;
            win_addr_nx = win_idx;
            win_adv     = !last_win;
            state_nx    = last_win ? ST_DONE : ST_CLEAR;
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
      block_change_nx = (state_nx == ST_CLEAR);
      busy_nx         = (state_nx != ST_IDLE);
      done_nx         = (state_nx == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= ST_IDLE;
         pix_valid    <= 1'b0;
         block_change <= 1'b0;
         win_done     <= 1'b0;
         win_addr     <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_nx;
         pix_valid    <= rd_en;
         block_change <= block_change_nx;
         win_done     <= win_done_nx;
         win_addr     <= win_addr_nx;
         busy         <= busy_nx;
         done         <= done_nx;
      end
   end

endmodule

// File: tb/tb_pool_window_feeder.sv
// Randomized bench for pool_window_feeder: a 4x4 and a 5x5 instance, each with a RAM model,
// a pooling-register model and a window-level reference of addresses, maxima and event timing.
module tb_pool_window_feeder;

   localparam int DW = 16;
   localparam int AW = 10;
   localparam int OW_W = 8;
   localparam int P = 2;
   localparam int TIMEOUT = 400;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic            start_s   [2];
   logic            hold_s    [2];
   logic            rd_en_s   [2];
   logic [AW-1:0]   rd_addr_s [2];
   logic [DW-1:0]   rd_data_s [2];
   logic [DW-1:0]   pix_s     [2];
   logic            pv_s      [2];
   logic            bc_s      [2];
   logic            wd_s      [2];
   logic [OW_W-1:0] wa_s      [2];
   logic            busy_s    [2];
   logic            done_s    [2];

   pool_window_feeder #(
      .IMG_W(4), .IMG_H(4), .POOL(P), .DW(DW), .ADDR_W(AW), .OADDR_W(OW_W)
   ) u_dut0 (
      .clk(clk), .rst(rst), .start(start_s[0]), .hold(hold_s[0]),
      .rd_en(rd_en_s[0]), .rd_addr(rd_addr_s[0]), .rd_data(rd_data_s[0]),
      .pix(pix_s[0]), .pix_valid(pv_s[0]), .block_change(bc_s[0]),
      .win_done(wd_s[0]), .win_addr(wa_s[0]), .busy(busy_s[0]), .done(done_s[0])
   );

   pool_window_feeder #(
      .IMG_W(5), .IMG_H(5), .POOL(P), .DW(DW), .ADDR_W(AW), .OADDR_W(OW_W)
   ) u_dut1 (
      .clk(clk), .rst(rst), .start(start_s[1]), .hold(hold_s[1]),
      .rd_en(rd_en_s[1]), .rd_addr(rd_addr_s[1]), .rd_data(rd_data_s[1]),
      .pix(pix_s[1]), .pix_valid(pv_s[1]), .block_change(bc_s[1]),
      .win_done(wd_s[1]), .win_addr(wa_s[1]), .busy(busy_s[1]), .done(done_s[1])
   );

   logic [DW-1:0] mem [2][32];
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous single-port RAMs: data valid the cycle after the read strobe.
   always @(posedge clk) begin
      for (int u = 0; u < 2; u++)
         if (rd_en_s[u]) rd_data_s[u] <= mem[u][rd_addr_s[u][4:0]];
   end

   int checks = 0;
   int passed = 0;

   int wd_cnt [2], dn_cnt [2], pv_cnt [2], rd_cnt [2];
   int ovl [2], pixbad [2], busy_cnt [2], done_cyc [2];
   int t0 [2], extra [2];
   bit chk_t [2];
   int rd_buf [2][16];
   logic [DW-1:0] acc [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic int img_w(input int u);
      return (u == 0) ? 4 : 5;
   endfunction

   function automatic int n_win(input int u);
      return (img_w(u) / P) * (img_w(u) / P);
   endfunction

   // Address of pixel i (row-major inside the window) of window k.
   function automatic int exp_addr(input int u, input int k, input int i);
      int ow = img_w(u) / P;
      return ((k / ow) * P + i / P) * img_w(u) + (k % ow) * P + i % P;
   endfunction

   function automatic logic [DW-1:0] exp_max(input int u, input int k);
      logic [DW-1:0] m = '0;
      for (int i = 0; i < P * P; i++)
         if (mem[u][exp_addr(u, k, i)] > m) m = mem[u][exp_addr(u, k, i)];
      return m;
   endfunction

   task automatic monitor();
      for (int u = 0; u < 2; u++) begin
         if (!rst) begin
            wd_cnt[u] = 0; dn_cnt[u] = 0; pv_cnt[u] = 0; rd_cnt[u] = 0; acc[u] = '0;
         end else begin
            if (wd_s[u]) begin
               check($sformatf("u%0d_win_addr", u), 32'(wa_s[u]), wd_cnt[u]);
               check($sformatf("u%0d_win_max", u), 32'(acc[u]), 32'(exp_max(u, wd_cnt[u])));
               check($sformatf("u%0d_pix_per_win", u), pv_cnt[u], P * P);
               check($sformatf("u%0d_reads_per_win", u), rd_cnt[u], P * P);
               for (int i = 0; i < P * P; i++)
                  check($sformatf("u%0d_rd_addr_w%0d_p%0d", u, wd_cnt[u], i),
                        rd_buf[u][i], exp_addr(u, wd_cnt[u], i));
               if (chk_t[u])
                  check($sformatf("u%0d_win_done_cycle", u), cyc,
                        t0[u] + 1 + (wd_cnt[u] + 1) * (P * P + 1) + extra[u]);
               wd_cnt[u]++;
            end
            if (done_s[u]) begin
               check($sformatf("u%0d_done_with_win_done", u), 32'(wd_s[u]), 1);
               dn_cnt[u]++;
               done_cyc[u] = cyc;
            end
            if (busy_s[u]) busy_cnt[u]++;
            if (bc_s[u] && pv_s[u]) ovl[u]++;
            if (!pv_s[u] && pix_s[u] != '0) pixbad[u]++;
            if (bc_s[u]) begin
               pv_cnt[u] = 0;
               rd_cnt[u] = 0;
            end
            if (pv_s[u]) pv_cnt[u]++;
            if (rd_en_s[u]) begin
               if (rd_cnt[u] < 16) rd_buf[u][rd_cnt[u]] = int'(rd_addr_s[u]);
               rd_cnt[u]++;
            end
            // Pooling register: clear at end of a block_change cycle, else absorb qualified pixels.
            if (bc_s[u]) acc[u] = '0;
            else if (pv_s[u] && pix_s[u] > acc[u]) acc[u] = pix_s[u];
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input int u, input string tag);
      check($sformatf("%s_u%0d_rd_en", tag, u), 32'(rd_en_s[u]), 0);
      check($sformatf("%s_u%0d_rd_addr", tag, u), 32'(rd_addr_s[u]), 0);
      check($sformatf("%s_u%0d_pix", tag, u), 32'(pix_s[u]), 0);
      check($sformatf("%s_u%0d_pix_valid", tag, u), 32'(pv_s[u]), 0);
      check($sformatf("%s_u%0d_block_change", tag, u), 32'(bc_s[u]), 0);
      check($sformatf("%s_u%0d_win_done", tag, u), 32'(wd_s[u]), 0);
      check($sformatf("%s_u%0d_win_addr", tag, u), 32'(wa_s[u]), 0);
      check($sformatf("%s_u%0d_busy", tag, u), 32'(busy_s[u]), 0);
      check($sformatf("%s_u%0d_done", tag, u), 32'(done_s[u]), 0);
   endtask

   task automatic fill_ramp(input int u);
      for (int i = 0; i < 32; i++) mem[u][i] = DW'(i);
   endtask

   task automatic fill_rand(input int u);
      for (int i = 0; i < 32; i++) mem[u][i] = DW'($urandom);
   endtask

   // hmode: 0 no hold, 1 hold during cycles c2..c4, 2 random hold (timing unchecked).
   task automatic run_map(input int u, input int hmode, input int restart_at);
      int n = 0;
      wd_cnt[u] = 0; dn_cnt[u] = 0; ovl[u] = 0; pixbad[u] = 0;
      busy_cnt[u] = 0; done_cyc[u] = -1;
      t0[u] = cyc;
      extra[u] = (hmode == 1) ? 3 : 0;
      chk_t[u] = (hmode != 2);
      start_s[u] = 1'b1;
      tick();
      start_s[u] = 1'b0;
      while (dn_cnt[u] == 0 && n < TIMEOUT) begin
         if (hmode == 1) hold_s[u] = (cyc >= t0[u] + 2) && (cyc <= t0[u] + 4);
         else if (hmode == 2) hold_s[u] = ($urandom_range(0, 3) == 0);
         else hold_s[u] = 1'b0;
         start_s[u] = (restart_at > 0) && (cyc == t0[u] + restart_at);
         tick();
         n++;
      end
      hold_s[u] = 1'b0;
      start_s[u] = 1'b0;
      repeat (6) tick();
      check($sformatf("u%0d_finished_in_time", u), 32'(n < TIMEOUT), 1);
      check($sformatf("u%0d_win_done_total", u), wd_cnt[u], n_win(u));
      check($sformatf("u%0d_done_total", u), dn_cnt[u], 1);
      check($sformatf("u%0d_bc_pv_overlap", u), ovl[u], 0);
      check($sformatf("u%0d_pix_nonzero_when_invalid", u), pixbad[u], 0);
      check($sformatf("u%0d_busy_cycles", u), busy_cnt[u], done_cyc[u] - t0[u]);
      if (chk_t[u])
         check($sformatf("u%0d_done_cycle", u), done_cyc[u],
               t0[u] + 1 + n_win(u) * (P * P + 1) + extra[u]);
   endtask

   initial begin
      rst = 1'b0;
      for (int u = 0; u < 2; u++) begin
         start_s[u] = 1'b0;
         hold_s[u] = 1'b0;
         chk_t[u] = 1'b0;
         extra[u] = 0;
         t0[u] = 0;
         acc[u] = '0;
         fill_ramp(u);
      end
      repeat (3) tick();
      check_zero(0, "reset");
      check_zero(1, "reset");
      rst = 1'b1;
      repeat (2) tick();

      // 4x4 ramp: maxima 5, 7, 13, 15 at c6/c11/c16/c21.
      fill_ramp(0);
      run_map(0, 0, 0);

      // 5x5 map: trailing row/column never read.
      fill_rand(1);
      run_map(1, 0, 0);

      // Three hold cycles in window 0 READ.
      fill_rand(0);
      run_map(0, 1, 0);

      // Reset mid-map at c8, outputs cleared at c9, then a full fresh run.
      fill_rand(0);
      wd_cnt[0] = 0; dn_cnt[0] = 0; extra[0] = 0; chk_t[0] = 1'b1;
      t0[0] = cyc;
      start_s[0] = 1'b1;
      tick();
      start_s[0] = 1'b0;
      while (cyc < t0[0] + 8) tick();
      rst = 1'b0;
      tick();
      check_zero(0, "mid_reset");
      rst = 1'b1;
      repeat (2) tick();
      run_map(0, 0, 0);

      // Second start at c4 while busy must be ignored.
      fill_rand(0);
      run_map(0, 0, 4);

      for (int r = 0; r < 4; r++) begin
         fill_rand(0);
         run_map(0, 2, 0);
         fill_rand(1);
         run_map(1, 0, 0);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/pool_window_feeder.md
# pool_window_feeder

Window sequencer that drives the max-pooling accumulator. Reads a row-major feature map from a single-port synchronous RAM and streams each POOL×POOL window's pixels to the pooling unit. Drives the accumulator's per-window clear (`num_block_change`) and pixel-qualify (`i_2`) controls. Pulses `win_done` with the output index when the accumulator holds the finished window maximum, so a downstream writer can capture it.

## Interface
- IMG_W, 28, feature-map width in pixels
- IMG_H, 28, feature-map height in pixels
- POOL, 2, window edge; stride equals POOL; trailing rows/cols that do not fill a window are dropped
- DW, 16, pixel width
- ADDR_W, 10, read-address width (≥ clog2(IMG_W*IMG_H))
- OADDR_W, 8, output-index width (≥ clog2((IMG_W/POOL)*(IMG_H/POOL)))

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to process one feature map; ignored while busy
- hold  in  1  stall; honored only in READ state
- rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_W  RAM read address
- rd_data  in  DW  RAM data, valid one cycle after rd_en
- pix  out  DW  pixel to pooling unit; equals rd_data when pix_valid, else 0
- pix_valid  out  1  connects to pooling `i_2`; rd_en delayed one cycle
- block_change  out  1  connects to pooling `num_block_change`
- win_done  out  1  pooling output holds the final max of window win_addr this cycle
- win_addr  out  OADDR_W  output index wr*(IMG_W/POOL)+wc
- busy  out  1  high from the first CLEAR cycle through DONE
- done  out  1  one-cycle pulse, coincident with the last win_done

## Operation
- States: IDLE, CLEAR, READ, WAIT, DONE.
- IDLE: start=1 → CLEAR, with window counters (wr, wc) = 0.
- CLEAR, 1 cycle:
  - block_change=1, rd_en=1 for window pixel (dr, dc) = (0, 0).
  - If a previous window exists, win_done=1 with that window's win_addr.
  - → READ. If POOL=1 → WAIT.
- READ: issues reads for the remaining POOL²−1 pixels, dc fastest.
  - hold=1: rd_en=0, counters frozen, state held.
  - After the last read → WAIT.
- WAIT, 1 cycle: no read; the last pixel is presented. Next window exists → CLEAR, else → DONE.
- DONE, 1 cycle: win_done=1 for the last window, done=1 → IDLE.
- Address: rd_addr = (wr*POOL+dr)*IMG_W + wc*POOL + dc.
- Window order: wc fastest, then wr. OW = IMG_W/POOL and OH = IMG_H/POOL, integer division.
- block_change is never asserted in a cycle with pix_valid=1. The pooling clear therefore never drops a pixel.
- Reset (rst=0) at any time, including mid-map:
  - state → IDLE, all counters → 0.
  - All outputs → 0: rd_en, rd_addr, pix, pix_valid, block_change, win_done, win_addr, busy, done.
  - Any read in flight is discarded.

## Timing
- start sampled at cycle c0 → first CLEAR at c1.
- Window period with no hold: POOL²+1 cycles.
- Window k's CLEAR is at c1 + k*(POOL²+1); its win_done is at c1 + (k+1)*(POOL²+1).
- Each hold cycle in READ adds one cycle to that window and shifts all later events.
- pix/pix_valid latency from rd_en: exactly 1 cycle.
- win_done lands one cycle after the window's last pix_valid. The pooling register has already absorbed that pixel.
- A concurrent block_change clears the pooling register only at the end of that cycle.

## Structure
- Shared package `cnn_pkg` holds:
  - the state enum type;
  - the default DW, IMG_W, IMG_H and POOL constants used across the CNN datapath.
- Sub-module `pool_addr_gen` holds:
  - the dc/dr/wc/wr counters with advance and last-pixel/last-window flags;
  - the rd_addr and win_addr computation.
- The FSM and output registers stay in the top.

## Test plan
- Basic 4×4 map, POOL=2, RAM contents 0..15 row-major, pooling instance attached:
  - start at c0 → win_done at c6/c11/c16/c21 with win_addr 0..3 and pooled values 5, 7, 13, 15;
  - done=1 at c21; busy high c1–c21.
- Odd 5×5 map, POOL=2, 4 windows: window 3 reads addresses 12, 13, 17, 18; row 4 and column 4 are never read.
- hold=1 for 3 cycles during window 0 READ (4×4 map): window 0 win_done at c9, all later events shifted by 3, maxima unchanged.
- Protocol check on all runs: block_change & pix_valid never both 1; exactly POOL² pix_valid pulses between consecutive block_change pulses.
- Reset mid-map: rst=0 at c8 → all outputs 0 at c9. A new start afterwards processes the full map from window 0 with correct maxima.
- Start while busy: second start at c4 is ignored. Exactly 4 win_done and 1 done are produced.
